snoop_bus_arbiter: RTL
======================

// Module: snoop_bus_arbiter
// PURPOSE
//  Arbitrates the shared 16-bit snooping bus between the processors of the cache-coherence system.
//  Each processor's L1 controller raises a request carrying a bus message {proc[1:0],opcode[1:0],tag[3:0],data[7:0]}.
//  The arbiter grants one requester at a time in round-robin order and broadcasts its message to all snoopers.
//  It collects snoop acknowledgements from every other processor, then reports completion to the issuer.
// PARAMETERS
//  N_PROC       3    number of processors/requesters (1..4, matches 2-bit proc field)
//  MSG_W        16   bus message width
//  ACK_TIMEOUT  15   max WAIT_ACK cycles before forced completion (>=1)
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-low reset
//  req          in   N_PROC         per-processor bus request; held until own done
//  req_msg      in   N_PROC*MSG_W   per-processor message; slice i = [i*MSG_W +: MSG_W]
//  snoop_ack    in   N_PROC         listener finished processing current broadcast (pulse or level)
//  grant        out  N_PROC         one-hot owner of bus, 0 when idle
//  bus          out  MSG_W          broadcast message; 16'hFFFF when idle
//  bus_valid    out  1              1-cycle strobe: new message on bus
//  done         out  N_PROC         1-cycle pulse to issuer: transaction complete
//  timeout_err  out  1              1-cycle pulse, coincident with done, when acks missing
//  busy         out  1              1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, grant=0, bus=16'hFFFF, bus_valid=0, done=0, timeout_err=0, rr_ptr=0, ack_seen=0, tmo_cnt=0; in-flight transaction dropped, no done.
//  - All outputs registered. FSM: IDLE -> BCAST -> WAIT_ACK -> DONE -> IDLE.
//  - IDLE: if |req, winner = first i with req[i] scanning rr_ptr, rr_ptr+1, ... mod N_PROC. Next edge: BCAST, grant=onehot(winner), bus=req_msg[winner] (latched), bus_valid=1.
//  - BCAST (1 cycle): next edge -> WAIT_ACK, bus_valid=0, ack_seen=0, tmo_cnt=0. snoop_ack ignored in BCAST.
//  - WAIT_ACK: each edge ack_seen |= snoop_ack & ~grant (winner's own ack ignored). Complete when (ack_seen|snoop_ack)|grant == all ones -> DONE. Else tmo_cnt++. When tmo_cnt reaches ACK_TIMEOUT -> DONE with timeout_err=1.
//  - DONE (1 cycle): done[winner]=1, grant=0, bus=16'hFFFF, rr_ptr=(winner+1) mod N_PROC. Next edge -> IDLE, done=0, timeout_err=0. Gives requester one cycle to drop req before re-arbitration.
//  - bus and grant stable from BCAST through WAIT_ACK. req/req_msg changes after the grant edge have no effect on the current transaction.
//  - Latency with all acks present at first WAIT_ACK sample:
//      edge0 sample req, edge1 grant/bus_valid, edge2 WAIT_ACK, edge3 done=1, edge4 IDLE.
//    Min req-to-req turnaround 5 cycles.
//  - N_PROC==1: no listeners; completion condition true on first WAIT_ACK edge.
//  - Simultaneous completion and timeout on same edge: completion wins, timeout_err=0.
//  - tmo_cnt width $clog2(ACK_TIMEOUT+1); no wrap possible.
// STRUCTURE
//  - coherence_pkg: message field offsets/widths (PROC, OPCODE, TAG, DATA), opcode encodings, IDLE_MSG=16'hFFFF, arbiter state encoding.
//  - Sub-module rr_arbiter: combinational rotating-priority picker (req, rr_ptr -> onehot winner, any).
//  - Top holds FSM, latches, ack collection, timeout counter.
// TESTING (N_PROC=3, ACK_TIMEOUT=15)
//  - Single request:
//      stimulus: req=3'b010, msg1=16'h5A3C; P0,P2 ack before edge3.
//      response: grant=3'b010 and bus=16'h5A3C at edge1; bus_valid high only edge1..2; done=3'b010 edge3; bus=16'hFFFF, grant=0 edge3.
//  - Round-robin:
//      stimulus: req=3'b111 held; each requester drops req after own done; rr_ptr=0.
//      response: grants in order 001,010,100, each done before next grant.
//  - Fairness:
//      stimulus: after P2 served, req=3'b101.
//      response: P0 granted before P2 re-served.
//  - Staggered pulsed acks:
//      stimulus: P1 issues; P0 acks 1 cycle at edge3; P2 acks 1 cycle at edge6; P1 asserts own ack throughout.
//      response: done[1] at edge7; timeout_err=0.
//  - Timeout:
//      stimulus: P0 issues; only P1 acks.
//      response: done=3'b001 with timeout_err=1 after 15 WAIT_ACK edges (edge17); then IDLE.
//  - Reset mid WAIT_ACK:
//      stimulus: reset low asynchronously.
//      response: grant=0, bus=16'hFFFF, busy=0 immediately; no done pulse; after release the pending req is re-granted starting from rr_ptr=0.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared definitions for the coherence snooping bus: message layout, opcodes,
// idle bus pattern and arbiter state encoding.
package coherence_pkg;

  localparam int BUS_MSG_W  = 16;
  localparam int PROC_LSB   = 14;
  localparam int PROC_W     = 2;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = 2;
  localparam int TAG_LSB    = 8;
  localparam int TAG_W      = 4;
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 8;

  localparam logic [BUS_MSG_W-1:0] IDLE_MSG = 16'hFFFF;

  typedef enum logic [OPCODE_W-1:0] {
    OP_BUS_RD   = 2'd0,
    OP_BUS_RDX  = 2'd1,
    OP_BUS_UPGR = 2'd2,
    OP_BUS_WB   = 2'd3
  } opcode_e;

  typedef struct packed {
    logic [PROC_W-1:0] proc;
    opcode_e           opcode;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bus_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BCAST    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  function automatic logic [PROC_W-1:0] msg_proc(input logic [BUS_MSG_W-1:0] msg);
    return msg[PROC_LSB +: PROC_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the first requester at or after ptr
// (wrapping modulo N) wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      int i;
      i = int'(ptr) + off;
      if (i >= N) i = i - N;
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = PW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snooping bus: broadcasts the winner's message,
// collects snoop acks from every other processor, then signals done to the issuer.
module snoop_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int N_PROC      = 3,
  parameter int MSG_W       = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_PROC-1:0]       req,
  input  logic [N_PROC*MSG_W-1:0] req_msg,
  input  logic [N_PROC-1:0]       snoop_ack,
  output logic [N_PROC-1:0]       grant,
  output logic [MSG_W-1:0]        bus,
  output logic                    bus_valid,
  output logic [N_PROC-1:0]       done,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [MSG_W-1:0] IDLE_BUS = MSG_W'(IDLE_MSG);

  arb_state_e        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [N_PROC-1:0] ack_seen;
  logic [TW-1:0]     tmo_cnt;

  logic [N_PROC-1:0] pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              all_acked;

  rr_arbiter #(.N(N_PROC), .PW(PW)) u_rr (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The owner counts as acked, so a single-processor system completes at once.
  assign all_acked = &(ack_seen | snoop_ack | grant);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      bus         <= IDLE_BUS;
      bus_valid   <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      rr_ptr      <= '0;
      win_idx     <= '0;
      ack_seen    <= '0;
      tmo_cnt     <= '0;
    end else begin
      bus_valid   <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_BCAST;
            grant     <= pick_onehot;
            bus       <= req_msg[pick_idx*MSG_W +: MSG_W];
            bus_valid <= 1'b1;
            win_idx   <= pick_idx;
            busy      <= 1'b1;
          end
        end
        ST_BCAST: begin
          state    <= ST_WAIT_ACK;
          ack_seen <= '0;
          tmo_cnt  <= '0;
        end
        ST_WAIT_ACK: begin
          ack_seen <= ack_seen | (snoop_ack & ~grant);
          // Completion is checked first so it wins over a timeout on the same edge.
          if (all_acked || tmo_cnt == TMO_LAST) begin
            state       <= ST_DONE;
            done        <= grant;
            grant       <= '0;
            bus         <= IDLE_BUS;
            timeout_err <= !all_acked;
            rr_ptr      <= (win_idx == PW'(N_PROC - 1)) ? '0 : win_idx + PW'(1);
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
